// File: rtl/pwm_capture.sv
// PWM input capture peripheral: measures period and high time of an external
// PWM line and exposes them, with control and sticky status, on the peripheral bus.
module pwm_capture #(
  parameter logic [31:0] base_address = 32'h8000_0100,
  parameter int          N            = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pwm_in,
  input  logic [31:0] address,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic [63:0] write_data,
  output logic [63:0] read_data,
  output logic        read_valid,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam logic [N-1:0] CNT_ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] CNT_ZERO = {N{1'b0}};
  localparam logic [N-1:0] CNT_MAX  = {N{1'b1}};

  state_t       state_r, state_next_s;
  logic [N-1:0] counter_r, counter_next_s;
  logic [N-1:0] high_latch_r, high_latch_next_s;
  logic [N-1:0] period_r, high_r;
  logic         sync1_r, sync2_r, prev_r;
  logic         enable_r, irq_en_r;
  logic         valid_r, overflow_r;
  logic         rise_s, fall_s;
  logic         capture_s, ovf_set_s;
  logic         sel_ctrl_s, sel_status_s, sel_period_s, sel_high_s;
  logic         wr_ctrl_s, w1c_valid_s, w1c_ovf_s;
  logic         valid_next_s, overflow_next_s;
  logic         enable_next_s, irq_en_next_s;
  logic [63:0]  rd_mux_s;
  logic         unused_s;

  assign rise_s = sync2_r & ~prev_r;
  assign fall_s = ~sync2_r & prev_r;

  assign sel_ctrl_s   = (address == base_address);
  assign sel_status_s = (address == (base_address + 32'h0000_0008));
  assign sel_period_s = (address == (base_address + 32'h0000_0010));
  assign sel_high_s   = (address == (base_address + 32'h0000_0018));

  assign wr_ctrl_s   = write_enable & sel_ctrl_s;
  assign w1c_valid_s = write_enable & sel_status_s & write_data[0];
  assign w1c_ovf_s   = write_enable & sel_status_s & write_data[1];

  // A capture or overflow in the same cycle as a W1C clear takes priority.
  assign valid_next_s    = capture_s | (valid_r & ~w1c_valid_s);
  assign overflow_next_s = ovf_set_s | (overflow_r & ~w1c_ovf_s);
  assign enable_next_s   = wr_ctrl_s ? write_data[0] : enable_r;
  assign irq_en_next_s   = wr_ctrl_s ? write_data[1] : irq_en_r;

  assign unused_s = ^write_data[63:2];

  // Measurement FSM next-state, counter and capture decisions.
  always_comb begin
    state_next_s      = state_r;
    counter_next_s    = counter_r;
    high_latch_next_s = high_latch_r;
    capture_s         = 1'b0;
    ovf_set_s         = 1'b0;
    case (state_r)
      IDLE: begin
        counter_next_s    = CNT_ZERO;
        high_latch_next_s = CNT_ZERO;
        if (enable_r) begin
          state_next_s = ARM;
        end else begin
          state_next_s = IDLE;
        end
      end
      ARM: begin
        if (!enable_r) begin
          state_next_s   = IDLE;
          counter_next_s = CNT_ZERO;
        end else if (rise_s) begin
          state_next_s      = MEASURE;
          counter_next_s    = CNT_ONE;
          high_latch_next_s = CNT_ZERO;
        end else begin
          counter_next_s = CNT_ZERO;
        end
      end
      MEASURE: begin
        if (!enable_r) begin
          state_next_s   = IDLE;
          counter_next_s = CNT_ZERO;
        end else if (rise_s) begin
          capture_s         = 1'b1;
          counter_next_s    = CNT_ONE;
          high_latch_next_s = CNT_ZERO;
        end else if (counter_r == CNT_MAX) begin
          // Saturated without a rise: abandon this period and re-arm.
          ovf_set_s      = 1'b1;
          state_next_s   = ARM;
          counter_next_s = CNT_ZERO;
        end else begin
          counter_next_s = counter_r + CNT_ONE;
          if (fall_s) begin
            high_latch_next_s = counter_r;
          end else begin
            high_latch_next_s = high_latch_r;
          end
        end
      end
      default: begin
        state_next_s   = IDLE;
        counter_next_s = CNT_ZERO;
      end
    endcase
  end

  // Register read multiplexer; unmapped addresses read as zero.
  always_comb begin
    rd_mux_s = 64'd0;
    if (sel_ctrl_s) begin
      rd_mux_s = {62'd0, irq_en_r, enable_r};
    end else if (sel_status_s) begin
      rd_mux_s = {61'd0, sync2_r, overflow_r, valid_r};
    end else if (sel_period_s) begin
      rd_mux_s = 64'(period_r);
    end else if (sel_high_s) begin
      rd_mux_s = 64'(high_r);
    end else begin
      rd_mux_s = 64'd0;
    end
  end

  // State, input synchronizer, result and bus registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= IDLE;
      counter_r    <= CNT_ZERO;
      high_latch_r <= CNT_ZERO;
      period_r     <= CNT_ZERO;
      high_r       <= CNT_ZERO;
      sync1_r      <= 1'b0;
      sync2_r      <= 1'b0;
      prev_r       <= 1'b0;
      enable_r     <= 1'b0;
      irq_en_r     <= 1'b0;
      valid_r      <= 1'b0;
      overflow_r   <= 1'b0;
      read_data    <= 64'd0;
      read_valid   <= 1'b0;
      irq          <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      counter_r    <= counter_next_s;
      high_latch_r <= high_latch_next_s;
      sync1_r      <= pwm_in;
      sync2_r      <= sync1_r;
      prev_r       <= sync2_r;
      enable_r     <= enable_next_s;
      irq_en_r     <= irq_en_next_s;
      valid_r      <= valid_next_s;
      overflow_r   <= overflow_next_s;
      if (capture_s) begin
        period_r <= counter_r;
        high_r   <= high_latch_r;
      end else begin
        period_r <= period_r;
        high_r   <= high_r;
      end
      read_valid <= read_enable;
      read_data  <= read_enable ? rd_mux_s : 64'd0;
      irq        <= valid_next_s & irq_en_next_s;
    end
  end

endmodule
